// File: rtl/e_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : e_stage_pipe
// Brief    : Pipeline stage register with main + skid entries, bubble insert,
//            whole-stage flush and a saturating back-pressure counter.
// Revision : 1.0 - initial release
// ============================================================================
module e_stage_pipe #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int EXC_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              in_bd,
  input  logic [EXC_W-1:0]  in_exc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_bd,
  output logic [EXC_W-1:0]  out_exc,
  output logic              out_bubble,
  output logic [1:0]        count,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [PC_W-1:0]   pc;
    logic              bd;
    logic [EXC_W-1:0]  exc;
    logic              bubble;
  } entry_t;

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  entry_t             main_q, main_d, skid_q, skid_d, w_new;
  logic               main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic               in_ready_q, in_ready_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic               w_accept, w_pop;

  assign w_accept = (in_valid | clr) & in_ready_q;
  assign w_pop    = main_v_q & out_ready;

  // A bubble keeps PC/BD so EPC can still be formed from it.
  always_comb begin
    w_new        = '0;
    w_new.pc     = in_pc;
    w_new.bd     = in_bd;
    if (clr) begin
      w_new.bubble = 1'b1;
    end else begin
      w_new.data   = in_data;
      w_new.exc    = in_exc;
    end
  end

  always_comb begin
    main_d   = main_q;
    main_v_d = main_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      main_d   = '0;
      main_v_d = 1'b0;
      skid_d   = '0;
      skid_v_d = 1'b0;
    end else if (w_pop && !w_accept) begin
      main_d   = skid_v_q ? skid_q : '0;
      main_v_d = skid_v_q;
      skid_d   = '0;
      skid_v_d = 1'b0;
    end else if (w_accept && !w_pop) begin
      if (!main_v_q) begin
        main_d   = w_new;
        main_v_d = 1'b1;
      end else begin
        skid_d   = w_new;
        skid_v_d = 1'b1;
      end
    end else if (w_accept && w_pop) begin
      if (skid_v_q) begin
        main_d = skid_q;
        skid_d = w_new;
      end else begin
        main_d = w_new;
      end
    end
    in_ready_d = ~skid_v_d;
  end

  always_comb begin
    stall_d = stall_q;
    if (main_v_q && !out_ready && (stall_q != c_cnt_max)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q     <= '0;
      main_v_q   <= 1'b0;
      skid_q     <= '0;
      skid_v_q   <= 1'b0;
      in_ready_q <= 1'b1;
      stall_q    <= '0;
    end else begin
      main_q     <= main_d;
      main_v_q   <= main_v_d;
      skid_q     <= skid_d;
      skid_v_q   <= skid_v_d;
      in_ready_q <= in_ready_d;
      stall_q    <= stall_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = main_v_q;
  assign out_data   = main_q.data;
  assign out_pc     = main_q.pc;
  assign out_bd     = main_q.bd;
  assign out_exc    = main_q.exc;
  assign out_bubble = main_q.bubble;
  assign count      = {1'b0, main_v_q} + {1'b0, skid_v_q};
  assign stall_cnt  = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_e_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_e_stage_pipe
// Brief    : Cycle-scripted vector bench for e_stage_pipe (CNT_W=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_e_stage_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, clr, in_valid, in_ready, in_bd;
  logic [31:0] in_data, in_pc;
  logic [4:0]  in_exc;
  logic        out_valid, out_ready, out_bd, out_bubble;
  logic [31:0] out_data, out_pc;
  logic [4:0]  out_exc;
  logic [1:0]  count, stall_cnt;

  int total = 0;
  int bad   = 0;

  e_stage_pipe #(.DATA_W(32), .PC_W(32), .EXC_W(5), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .flush(flush), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_pc(in_pc), .in_bd(in_bd), .in_exc(in_exc),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_pc(out_pc), .out_bd(out_bd), .out_exc(out_exc),
    .out_bubble(out_bubble), .count(count), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic fl, cl, iv; logic [31:0] d, pc; logic bd; logic [4:0] ex; logic ordy;
    logic ov; logic [31:0] od, opc; logic obd; logic [4:0] oex; logic obub;
    logic [1:0] cnt; logic ird; logic [1:0] stl;
  } vec_t;

  function automatic vec_t mk(
    input logic fl, cl, iv, input logic [31:0] d, pc, input logic bd,
    input logic [4:0] ex, input logic ordy,
    input logic ov, input logic [31:0] od, opc, input logic obd,
    input logic [4:0] oex, input logic obub, input logic [1:0] cnt,
    input logic ird, input logic [1:0] stl);
    vec_t v;
    v.fl = fl; v.cl = cl; v.iv = iv; v.d = d; v.pc = pc; v.bd = bd; v.ex = ex;
    v.ordy = ordy; v.ov = ov; v.od = od; v.opc = opc; v.obd = obd; v.oex = oex;
    v.obub = obub; v.cnt = cnt; v.ird = ird; v.stl = stl;
    return v;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d actual=%h required=%h", nm, row, act, exp);
    end
  endtask

  task automatic chk_outs(input int row, input logic ov, input logic [31:0] od,
                          input logic [31:0] opc, input logic obd,
                          input logic [4:0] oex, input logic obub,
                          input logic [1:0] cnt, input logic ird,
                          input logic [1:0] stl);
    chk("out_valid",  row, {31'd0, out_valid},  {31'd0, ov});
    chk("out_data",   row, out_data,            od);
    chk("out_pc",     row, out_pc,              opc);
    chk("out_bd",     row, {31'd0, out_bd},     {31'd0, obd});
    chk("out_exc",    row, {27'd0, out_exc},    {27'd0, oex});
    chk("out_bubble", row, {31'd0, out_bubble}, {31'd0, obub});
    chk("count",      row, {30'd0, count},      {30'd0, cnt});
    chk("in_ready",   row, {31'd0, in_ready},   {31'd0, ird});
    chk("stall_cnt",  row, {30'd0, stall_cnt},  {30'd0, stl});
  endtask

  task automatic idle_inputs();
    flush = 0; clr = 0; in_valid = 0; in_data = 0; in_pc = 0; in_bd = 0;
    in_exc = 0; out_ready = 0;
  endtask

  vec_t vt[21];

  initial begin
    // Each row: inputs held for one cycle, expected outputs after that edge.
    vt[0]  = mk(0,0,1,32'h1,32'h3000,0,0,1, 1,32'h1,32'h3000,0,0,0,1,1,0);
    vt[1]  = mk(0,0,1,32'h2,32'h3004,0,0,1, 1,32'h2,32'h3004,0,0,0,1,1,0);
    vt[2]  = mk(0,0,1,32'h3,32'h3008,0,0,1, 1,32'h3,32'h3008,0,0,0,1,1,0);
    vt[3]  = mk(0,0,1,32'h4,32'h300C,0,0,1, 1,32'h4,32'h300C,0,0,0,1,1,0);
    vt[4]  = mk(0,0,1,32'h5,32'h3010,0,0,1, 1,32'h5,32'h3010,0,0,0,1,1,0);
    vt[5]  = mk(0,0,0,32'h0,32'h0,   0,0,1, 0,32'h0,32'h0,   0,0,0,0,1,0);
    vt[6]  = mk(0,1,0,32'hAAAA,32'h3010,1,3,1, 1,32'h0,32'h3010,1,0,1,1,1,0);
    vt[7]  = mk(0,0,1,32'hDEADBEEF,32'h3014,0,10,1, 1,32'hDEADBEEF,32'h3014,0,10,0,1,1,0);
    vt[8]  = mk(0,1,1,32'hDEADBEEF,32'h3014,0,10,1, 1,32'h0,32'h3014,0,0,1,1,1,0);
    vt[9]  = mk(0,0,0,32'h0,32'h0,   0,0,1, 0,32'h0,32'h0,   0,0,0,0,1,0);
    vt[10] = mk(0,0,1,32'hA,32'h3100,0,0,0, 1,32'hA,32'h3100,0,0,0,1,1,0);
    vt[11] = mk(0,0,1,32'hB,32'h3104,1,0,0, 1,32'hA,32'h3100,0,0,0,2,0,1);
    vt[12] = mk(0,0,1,32'hC,32'h3108,0,2,0, 1,32'hA,32'h3100,0,0,0,2,0,2);
    vt[13] = mk(0,0,1,32'hC,32'h3108,0,2,1, 1,32'hB,32'h3104,1,0,0,1,1,2);
    vt[14] = mk(0,0,1,32'hC,32'h3108,0,2,1, 1,32'hC,32'h3108,0,2,0,1,1,2);
    vt[15] = mk(0,0,0,32'h0,32'h0,   0,0,1, 0,32'h0,32'h0,   0,0,0,0,1,2);
    vt[16] = mk(0,0,1,32'hD,32'h3200,0,0,0, 1,32'hD,32'h3200,0,0,0,1,1,2);
    vt[17] = mk(0,0,1,32'hE,32'h3204,0,0,0, 1,32'hD,32'h3200,0,0,0,2,0,3);
    vt[18] = mk(1,0,1,32'hF,32'h3208,0,0,0, 0,32'h0,32'h0,   0,0,0,0,1,3);
    vt[19] = mk(1,0,1,32'h11,32'h3300,0,0,1, 0,32'h0,32'h0,  0,0,0,0,1,3);
    vt[20] = mk(0,0,0,32'h0,32'h0,   0,0,1, 0,32'h0,32'h0,   0,0,0,0,1,3);

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_outs(-1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    reset = 1'b0;

    for (int i = 0; i < 21; i++) begin
      flush = vt[i].fl; clr = vt[i].cl; in_valid = vt[i].iv; in_data = vt[i].d;
      in_pc = vt[i].pc; in_bd = vt[i].bd; in_exc = vt[i].ex;
      out_ready = vt[i].ordy;
      @(posedge clk);
      #1;
      chk_outs(i, vt[i].ov, vt[i].od, vt[i].opc, vt[i].obd, vt[i].oex,
               vt[i].obub, vt[i].cnt, vt[i].ird, vt[i].stl);
    end

    // Clear the counter, then accept in the very first cycle after release.
    idle_inputs();
    reset = 1'b1;
    #2;
    chk("rst_stall", 100, {30'd0, stall_cnt}, 32'd0);
    reset = 1'b0;
    in_valid = 1; in_data = 32'h600D; in_pc = 32'h3400;
    @(posedge clk);
    #1;
    chk_outs(101, 1, 32'h600D, 32'h3400, 0, 0, 0, 1, 1, 0);

    // Five stalled edges: counter saturates at 3.
    in_valid = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("sat_stall", 110 + k, {30'd0, stall_cnt}, (k < 3) ? k + 1 : 3);
    end

    // Asynchronous reset between edges clears everything immediately.
    #2;
    reset = 1'b1;
    #1;
    chk_outs(120, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_outs(121, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
